peak_search_scheduler: RTL and testbench
========================================

Name: peak_search_scheduler

Overview:
- Time-multiplexed replacement for the parallel peak-finder bank.
- Accepts one frame of NUM_XCORRS cross-correlation vectors, each 2*MAX_LAGS+1 lags, and buffers it.
- Shares a single signed comparator across all pairs, scanning pair by pair and lag by lag.
- Emits per-pair peak lag indices to the direction-of-arrival stage over a valid/ready handshake.

Parameters:
- MAX_LAGS, 11, lags per side; vector length is 2*MAX_LAGS+1.
- NUM_XCORRS, 6, number of microphone-pair correlation vectors per frame.
- NUM_BITS_XCORRS, 32, width of one signed correlation value.
- BITS_PER_XCORR, 6, width of one output lag index; must be at least $clog2(2*MAX_LAGS+1).
- MIN_XCORR_VAL, 1000, signed detection threshold for a pair's peak.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- dataIn, in, NUM_XCORRS*(2*MAX_LAGS+1)*NUM_BITS_XCORRS, frame, signed, packed. Pair p, lag l sits at word index p*(2*MAX_LAGS+1)+l.
- dataInValid, in, 1, frame present.
- dataInReady, out, 1, block can accept a frame.
- dataOut, out, NUM_XCORRS*BITS_PER_XCORR, peak lag index per pair; pair p in field p, field 0 at the LSBs.
- dataOutFound, out, NUM_XCORRS, bit p is 1 if pair p's peak is at least MIN_XCORR_VAL.
- dataOutValid, out, 1, result present.
- dataOutReady, in, 1, consumer takes the result.
- busy, out, 1, high in SCAN or DONE.

Behaviour:
- Reset values: dataOut=0, dataOutFound=0, dataOutValid=0, busy=0, dataInReady=1. State is IDLE; pair counter p=0, lag counter l=0.
- State IDLE:
  - dataInReady=1.
  - On dataInValid&&dataInReady, the whole dataIn is registered into the frame buffer, p=0, l=0, next state SCAN.
  - dataInValid is ignored in every other state; the buffer is not overwritten.
- State SCAN: one buffer word (p,l) is processed per cycle.
  - l==0: runMax=buf[p][0], runIdx=0.
  - l>0: if buf[p][l] > runMax (signed, strict), then runMax=buf[p][l] and runIdx=l. Ties therefore keep the lowest lag index.
  - l==2*MAX_LAGS: the pair's final max and index use this cycle's compare result. The result is committed to field p:
    - If final max >= MIN_XCORR_VAL: field = index, found bit = 1.
    - Otherwise: field = MAX_LAGS (zero lag), found bit = 0.
  - After the commit, l wraps to 0 and p increments. If p==NUM_XCORRS-1, the next state is DONE.
  - Field p is written only at its commit. The other fields keep previous values until committed.
- State DONE:
  - dataOutValid=1. dataOut and dataOutFound are held stable while dataOutValid&&!dataOutReady.
  - On dataOutReady: dataOutValid=0 next cycle, next state IDLE, dataInReady=1 next cycle.
  - dataOut and dataOutFound retain their values after the handshake.
- Latency:
  - The accept edge is edge 0.
  - The scan occupies edges 1..NUM_XCORRS*(2*MAX_LAGS+1), which is 138 edges at the defaults.
  - dataOutValid rises after edge 138.
  - Minimum frame period with dataOutReady tied high is 140 cycles (accept, 138 scan, 1 DONE).
- Lag index mapping: raw index l corresponds to lag l-MAX_LAGS. Output fields are raw indices in 0..2*MAX_LAGS.
- Arithmetic: comparisons are NUM_BITS_XCORRS-bit signed. MIN_XCORR_VAL is sign-extended to NUM_BITS_XCORRS. No saturation is needed.
- Reset mid-operation: reset is asynchronous from any state to IDLE with all reset values. The partial scan is discarded and no dataOutValid pulse is produced.

Test Plan:
1. Single peak per pair: pair p has 5000 at lag p+3 and 0 elsewhere -> dataOut fields {8,7,6,5,4,3} (p=5..0), dataOutFound=6'b111111, dataOutValid rises exactly 138 cycles after the accept edge.
2. Threshold boundary: pair 0 all 999 and pair 1 peak exactly 1000 at lag 2 -> field0=11 with found[0]=0; field1=2 with found[1]=1.
3. Signed values and ties: pair 0 all -5, with 2000 at lags 4 and 9 -> field0=4. Pair 1 all negative with max -3 at lag 7 -> field1=11, found[1]=0.
4. Backpressure: dataOutReady=0 for 20 cycles after dataOutValid, with a second frame offered -> outputs stable, dataInReady=0, second frame not accepted. Raise dataOutReady -> IDLE next cycle, then the second frame is accepted.
5. Reset mid-scan: assert rst 50 cycles after accept -> outputs 0 and dataInReady=1 immediately, with no dataOutValid. A new frame after release produces correct results.
6. Back-to-back frames with dataOutReady=1 and dataInValid held high -> one result every 140 cycles, each matching its own frame.

Source files
------------

// File: rtl/peak_search_scheduler.sv
// Time-multiplexed peak finder: buffers one frame of cross-correlation vectors and
// scans it word by word with one shared signed comparator, reporting a peak lag per pair.
module peak_search_scheduler #(
  parameter int MAX_LAGS        = 11,
  parameter int NUM_XCORRS      = 6,
  parameter int NUM_BITS_XCORRS = 32,
  parameter int BITS_PER_XCORR  = 6,
  parameter int MIN_XCORR_VAL   = 1000
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUM_XCORRS*(2*MAX_LAGS+1)*NUM_BITS_XCORRS-1:0] dataIn,
  input  logic                                                 dataInValid,
  output logic                                                 dataInReady,
  output logic [NUM_XCORRS*BITS_PER_XCORR-1:0]                 dataOut,
  output logic [NUM_XCORRS-1:0]                                dataOutFound,
  output logic                                                 dataOutValid,
  input  logic                                                 dataOutReady,
  output logic                                                 busy
);

  localparam int LEN       = 2*MAX_LAGS + 1;
  localparam int NUM_WORDS = NUM_XCORRS * LEN;
  localparam int NB        = NUM_BITS_XCORRS;
  localparam int BW        = BITS_PER_XCORR;
  localparam int LW        = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int PW        = (NUM_XCORRS > 1) ? $clog2(NUM_XCORRS) : 1;
  localparam int IW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic signed [NB-1:0] MIN_VAL = NB'(MIN_XCORR_VAL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state_r;
  logic        [PW-1:0]        p_r;
  logic        [LW-1:0]        l_r;
  logic signed [NB-1:0]        run_max_r;
  logic        [BW-1:0]        run_idx_r;
  logic        [NUM_XCORRS*BW-1:0] dout_r;
  logic        [NUM_XCORRS-1:0]    found_r;
  logic                        valid_r;
  logic                        in_ready_r;
  logic                        busy_r;
  logic signed [NB-1:0]        buf_r [NUM_WORDS];

  logic                        accept_s;
  logic        [IW-1:0]        word_idx_s;
  logic signed [NB-1:0]        word_s;
  logic signed [NB-1:0]        max_s;
  logic        [BW-1:0]        idx_s;
  logic                        found_s;
  logic        [BW-1:0]        field_s;

  assign dataInReady  = in_ready_r;
  assign dataOut      = dout_r;
  assign dataOutFound = found_r;
  assign dataOutValid = valid_r;
  assign busy         = busy_r;

  // Shared comparator: fold the current buffer word into the running max of the pair
  always_comb begin
    accept_s   = (state_r == IDLE) && dataInValid && in_ready_r;
    word_idx_s = IW'(p_r) * IW'(LEN) + IW'(l_r);
    word_s     = buf_r[word_idx_s];
    max_s      = run_max_r;
    idx_s      = run_idx_r;
    if (l_r == LW'(0)) begin
      max_s = word_s;
      idx_s = BW'(0);
    end else if (word_s > run_max_r) begin
      // strict compare keeps the lowest lag on ties
      max_s = word_s;
      idx_s = BW'(l_r);
    end else begin
      max_s = run_max_r;
      idx_s = run_idx_r;
    end
    found_s = (max_s >= MIN_VAL);
    field_s = found_s ? idx_s : BW'(MAX_LAGS);
  end

  // Frame buffer, loaded only on an accepted frame so later offers never disturb a scan
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        buf_r[i] <= dataIn[i*NB +: NB];
      end
    end
  end

  // Control FSM with registered handshake outputs and per-pair result commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      p_r        <= PW'(0);
      l_r        <= LW'(0);
      run_max_r  <= NB'(0);
      run_idx_r  <= BW'(0);
      dout_r     <= '0;
      found_r    <= '0;
      valid_r    <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= SCAN;
            p_r        <= PW'(0);
            l_r        <= LW'(0);
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        SCAN: begin
          run_max_r <= max_s;
          run_idx_r <= idx_s;
          if (l_r == LW'(LEN-1)) begin
            dout_r[p_r*BW +: BW] <= field_s;
            found_r[p_r]         <= found_s;
            l_r                  <= LW'(0);
            if (p_r == PW'(NUM_XCORRS-1)) begin
              p_r     <= PW'(0);
              state_r <= DONE;
              valid_r <= 1'b1;
            end else begin
              p_r <= p_r + PW'(1);
            end
          end else begin
            l_r <= l_r + LW'(1);
          end
        end
        DONE: begin
          if (dataOutReady) begin
            state_r    <= IDLE;
            valid_r    <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          p_r        <= PW'(0);
          l_r        <= LW'(0);
          valid_r    <= 1'b0;
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_peak_search_scheduler.sv
// Self-checking bench for peak_search_scheduler: table-driven frames, randomized frames
// against a max-then-first-index reference model, and handshake/reset corner sequences.
module tb_peak_search_scheduler;

  localparam int NUM = 6;
  localparam int LEN = 23;
  localparam int BW  = 6;
  localparam int FW  = NUM*LEN*32;

  logic              clk;
  logic              rst;
  logic [FW-1:0]     dataIn;
  logic              dataInValid;
  logic              dataInReady;
  logic [NUM*BW-1:0] dataOut;
  logic [NUM-1:0]    dataOutFound;
  logic              dataOutValid;
  logic              dataOutReady;
  logic              busy;

  peak_search_scheduler dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataInValid(dataInValid),
    .dataInReady(dataInReady), .dataOut(dataOut), .dataOutFound(dataOutFound),
    .dataOutValid(dataOutValid), .dataOutReady(dataOutReady), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   base;
    int   peak;
    int   lag_a;
    int   lag_b;
    int   exp_idx;
    logic exp_found;
  } pvec_t;

  pvec_t tbl [2][NUM];
  int    frames [8][NUM][LEN];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack(input int k);
    logic [FW-1:0] v;
    v = '0;
    for (int p = 0; p < NUM; p++)
      for (int l = 0; l < LEN; l++)
        v[(p*LEN+l)*32 +: 32] = frames[k][p][l];
    return v;
  endfunction

  // Reference: take the pair maximum, then the first lag holding it, then threshold.
  task automatic model(input int k, output logic [NUM*BW-1:0] eo, output logic [NUM-1:0] ef);
    eo = '0;
    ef = '0;
    for (int p = 0; p < NUM; p++) begin
      int mx;
      int first;
      mx = frames[k][p][0];
      for (int l = 1; l < LEN; l++) if (frames[k][p][l] > mx) mx = frames[k][p][l];
      first = -1;
      for (int l = 0; l < LEN; l++) if (first < 0 && frames[k][p][l] == mx) first = l;
      if (mx >= 1000) begin
        eo[p*BW +: BW] = BW'(first);
        ef[p] = 1'b1;
      end else begin
        eo[p*BW +: BW] = BW'(11);
        ef[p] = 1'b0;
      end
    end
  endtask

  task automatic fill_from_table(input int t, input int k);
    for (int p = 0; p < NUM; p++)
      for (int l = 0; l < LEN; l++)
        frames[k][p][l] = (l == tbl[t][p].lag_a || l == tbl[t][p].lag_b) ? tbl[t][p].peak
                                                                          : tbl[t][p].base;
  endtask

  task automatic gen_random(input int k);
    for (int p = 0; p < NUM; p++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int l = 0; l < LEN; l++) begin
        case (mode)
          0:       frames[k][p][l] = int'($urandom_range(0, 8)) * 300 - 1200;
          1:       frames[k][p][l] = int'($urandom);
          default: frames[k][p][l] = -int'($urandom_range(1, 5000));
        endcase
      end
    end
  endtask

  task automatic accept_frame(input int k);
    logic rdy;
    int   n;
    dataIn = pack(k);
    dataInValid = 1'b1;
    n = 0;
    do begin
      rdy = dataInReady;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 400);
    dataInValid = 1'b0;
    chk("accept", 64'(rdy), 64'(1));
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!dataOutValid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_model(input string nm, input int k);
    logic [NUM*BW-1:0] eo;
    logic [NUM-1:0]    ef;
    model(k, eo, ef);
    chk({nm, "_out"}, 64'(dataOut), 64'(eo));
    chk({nm, "_found"}, 64'(dataOutFound), 64'(ef));
  endtask

  task automatic handshake();
    logic [NUM*BW-1:0] held;
    held = dataOut;
    dataOutReady = 1'b1;
    @(posedge clk); #1;
    dataOutReady = 1'b0;
    chk("hs_valid_low", 64'(dataOutValid), 64'(0));
    chk("hs_in_ready", 64'(dataInReady), 64'(1));
    chk("hs_busy", 64'(busy), 64'(0));
    chk("hs_retain", 64'(dataOut), 64'(held));
  endtask

  initial begin
    int n;
    logic [NUM*BW-1:0] held_out;
    logic [NUM-1:0]    held_fnd;

    for (int p = 0; p < NUM; p++) tbl[0][p] = '{0, 5000, p+3, p+3, p+3, 1'b1};
    tbl[1][0] = '{999, 999, 0, 0, 11, 1'b0};
    tbl[1][1] = '{0, 1000, 2, 2, 2, 1'b1};
    tbl[1][2] = '{-5, 2000, 4, 9, 4, 1'b1};
    tbl[1][3] = '{-100, -3, 7, 7, 11, 1'b0};
    tbl[1][4] = '{32'sh80000000, 32'sh7FFFFFFF, 22, 22, 22, 1'b1};
    tbl[1][5] = '{1000, 1000, 0, 0, 0, 1'b1};
    fill_from_table(0, 0);
    fill_from_table(1, 1);
    for (int k = 2; k < 8; k++) gen_random(k);

    rst = 1'b1;
    dataIn = '0;
    dataInValid = 1'b0;
    dataOutReady = 1'b0;
    #2;
    chk("rst_out", 64'(dataOut), 64'(0));
    chk("rst_found", 64'(dataOutFound), 64'(0));
    chk("rst_valid", 64'(dataOutValid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(dataInReady), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven frames: single peaks, threshold boundary, signed values and ties
    for (int t = 0; t < 2; t++) begin
      accept_frame(t);
      chk("scan_busy", 64'(busy), 64'(1));
      wait_result(n);
      chk("latency", 64'(n), 64'(138));
      for (int p = 0; p < NUM; p++) begin
        chk($sformatf("t%0d_field%0d", t, p), 64'(dataOut[p*BW +: BW]), 64'(tbl[t][p].exp_idx));
        chk($sformatf("t%0d_found%0d", t, p), 64'(dataOutFound[p]), 64'(tbl[t][p].exp_found));
      end
      handshake();
    end

    // Random frames against the reference model
    for (int k = 2; k < 4; k++) begin
      accept_frame(k);
      wait_result(n);
      chk("rand_latency", 64'(n), 64'(138));
      check_model($sformatf("rand%0d", k), k);
      handshake();
    end

    // Backpressure with a second frame offered while DONE
    accept_frame(4);
    wait_result(n);
    check_model("bp_first", 4);
    held_out = dataOut;
    held_fnd = dataOutFound;
    dataIn = pack(5);
    dataInValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_out_stable", 64'(dataOut), 64'(held_out));
      chk("bp_fnd_stable", 64'(dataOutFound), 64'(held_fnd));
      chk("bp_valid_held", 64'(dataOutValid), 64'(1));
      chk("bp_in_ready", 64'(dataInReady), 64'(0));
    end
    dataOutReady = 1'b1;
    @(posedge clk); #1;
    dataOutReady = 1'b0;
    chk("bp_release_valid", 64'(dataOutValid), 64'(0));
    chk("bp_release_ready", 64'(dataInReady), 64'(1));
    @(posedge clk); #1;
    dataInValid = 1'b0;
    chk("bp_second_accept", 64'(dataInReady), 64'(0));
    chk("bp_second_busy", 64'(busy), 64'(1));
    wait_result(n);
    chk("bp_second_latency", 64'(n), 64'(138));
    check_model("bp_second", 5);
    handshake();

    // Reset in the middle of a scan
    accept_frame(6);
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out", 64'(dataOut), 64'(0));
    chk("mid_rst_found", 64'(dataOutFound), 64'(0));
    chk("mid_rst_valid", 64'(dataOutValid), 64'(0));
    chk("mid_rst_in_ready", 64'(dataInReady), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #3;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (dataOutValid) n++;
    end
    chk("mid_rst_no_valid", 64'(n), 64'(0));
    accept_frame(2);
    wait_result(n);
    chk("post_rst_latency", 64'(n), 64'(138));
    check_model("post_rst", 2);
    handshake();

    // Back-to-back frames with both sides always willing
    begin
      int   kin;
      int   kout;
      int   last;
      logic rdy;
      kin = 0;
      kout = 0;
      last = 0;
      dataOutReady = 1'b1;
      dataIn = pack(5);
      dataInValid = 1'b1;
      for (int cyc = 0; cyc < 700 && kout < 3; cyc++) begin
        rdy = dataInReady;
        @(posedge clk); #1;
        if (rdy) begin
          kin++;
          if (kin < 3) dataIn = pack(5 + kin);
        end
        if (dataOutValid) begin
          check_model($sformatf("b2b%0d", kout), 5 + kout);
          if (kout == 0) chk("b2b_first", 64'(cyc), 64'(138));
          else chk("b2b_period", 64'(cyc - last), 64'(140));
          last = cyc;
          kout++;
        end
      end
      chk("b2b_count", 64'(kout), 64'(3));
      dataInValid = 1'b0;
      dataOutReady = 1'b0;
    end

    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
